// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between an instruction-fetch requester and a
// load/store requester. Only one transaction is outstanding at a time.
//
// The data port normally wins arbitration. A streak counter tracks how many
// data grants have been made while a fetch was waiting. When the streak
// reaches STARVE_LIMIT, the waiting fetch wins the next arbitration.
//
// A transaction that sees no mem_ack for TIMEOUT busy cycles is aborted. The
// owner still gets its ready pulse, with resp_err set and rdata forced to zero,
// and the sticky bus_error flag is raised.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   if_req/if_addr    fetch request (always a word read)
//   if_ready/if_rdata one-cycle completion pulse and the registered read data
//   d_req/d_we/d_addr/d_wdata/d_size
//                     load/store request
//   d_ready/d_rdata   one-cycle completion pulse and the registered read data
//   mem_*             shared memory request (held stable while busy) and the
//                     ack/rdata coming back from the memory
//   resp_err          accompanies a ready pulse that ends an aborted transaction
//   bus_error         sticky; set by any timeout, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_ready,
  output logic [31:0] d_rdata,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,

  output logic        resp_err,
  output logic        bus_error
);

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam int         STREAK_W  = $clog2(STARVE_LIMIT + 1);
  localparam int         TMO_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [STREAK_W-1:0] d_streak;
  logic [TMO_W-1:0]    tmo_cnt;

  // Transaction fields captured at grant time; they feed the memory port so
  // the request stays stable for the whole transaction.
  logic                lat_we;
  logic [31:0]         lat_addr;
  logic [31:0]         lat_wdata;
  logic [1:0]          lat_size;

  logic                busy;
  logic                arb_open;
  logic                starving;
  logic                grant_i;
  logic                grant_d;
  logic                timed_out;
  logic                finish;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // The IDLE cycle that carries a ready pulse is a turnaround cycle, and no
  // grant is made in it. During that cycle the completed requester still holds
  // req high, so its req cannot be told apart from a new request and is
  // ignored. The other port is held off for the same cycle. That way, a data
  // port that immediately issues its next request still competes against a
  // waiting fetch on the following cycle, which lets the starvation limit
  // decide the winner.
  assign busy      = (state != IDLE);
  assign arb_open  = (state == IDLE) && !if_ready && !d_ready;
  assign starving  = (d_streak == STREAK_W'(STARVE_LIMIT));
  assign grant_i   = arb_open && if_req && (!d_req || starving);
  assign grant_d   = arb_open && d_req && !grant_i;

  // An ack in the last allowed cycle still counts as a normal completion.
  assign timed_out = busy && !mem_ack && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign finish    = busy && (mem_ack || timed_out);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every register in this file is written with non-blocking
  // assignments. This way all flops sample the values from before the edge,
  // whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and memory-port outputs
  // ---------------------------------------------------------------------------
  // NOTE: each signal gets its default value before the case statement. This
  // way no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    mem_size  = lat_size;

    unique case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt = BUSY_I;
        end else if (grant_d) begin
          state_nxt = BUSY_D;
        end
      end

      BUSY_I: begin
        mem_req = 1'b1;
        if (finish) begin
          state_nxt = IDLE;
        end
      end

      BUSY_D: begin
        mem_req = 1'b1;
        mem_we  = lat_we;
        if (finish) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= '0;
    end else if (grant_i) begin
      lat_we    <= 1'b0;
      lat_addr  <= if_addr;
      lat_wdata <= '0;
      lat_size  <= SIZE_WORD;
    end else if (grant_d) begin
      lat_we    <= d_we;
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
      lat_size  <= d_size;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation streak
  // ---------------------------------------------------------------------------
  // Counts only the data grants made while a fetch was waiting. A data grant
  // with no fetch pending resets the streak.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_streak <= '0;
    end else if (grant_i) begin
      d_streak <= '0;
    end else if (grant_d) begin
      if (!if_req) begin
        d_streak <= '0;
      end else if (!starving) begin
        d_streak <= d_streak + STREAK_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Busy-cycle timeout counter
  // ---------------------------------------------------------------------------
  // Held at zero in IDLE, so each transaction starts counting from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (!busy || finish) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Completion: ready pulses, read data, error flags
  // ---------------------------------------------------------------------------
  // An aborted transaction returns zero data, whatever its direction. A write
  // that completes normally leaves d_rdata untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      resp_err  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      resp_err <= 1'b0;

      if (finish) begin
        if (state == BUSY_I) begin
          if_ready <= 1'b1;
          if_rdata <= timed_out ? 32'h0 : mem_rdata;
        end else begin
          d_ready <= 1'b1;
          if (timed_out) begin
            d_rdata <= 32'h0;
          end else if (!lat_we) begin
            d_rdata <= mem_rdata;
          end
        end

        if (timed_out) begin
          resp_err  <= 1'b1;
          bus_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter with its default parameters
// (STARVE_LIMIT=4, TIMEOUT=16). Inputs change 1 ns after each rising edge.
// Outputs are sampled at the same point, after the edge has settled. Every
// expected value below is worked out by hand from the arbiter's behaviour.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_err;
  logic        bus_error;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT     (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_size   (d_size),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_size (mem_size),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .resp_err (resp_err),
    .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Keep the run finite even if something goes badly wrong.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_size    = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // ---------------- reset state ----------------
    ticks(2);
    check("rst_mem_req",   mem_req,   0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_size",  mem_size,  0);
    check("rst_if_ready",  if_ready,  0);
    check("rst_d_ready",   d_ready,   0);
    check("rst_resp_err",  resp_err,  0);
    check("rst_bus_error", bus_error, 0);
    check("rst_if_rdata",  if_rdata,  0);
    check("rst_d_rdata",   d_rdata,   0);
    reset = 1'b1;
    tick();

    // ---------------- single fetch ----------------
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    tick();                                  // grant edge
    check("f_mem_req",   mem_req,  1);
    check("f_mem_addr",  mem_addr, 32'h100);
    check("f_mem_we",    mem_we,   0);
    check("f_mem_size",  mem_size, 2'b10);
    check("f_if_ready0", if_ready, 0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h00A0_0093;
    tick();                                  // ack sampled
    check("f_if_ready",  if_ready, 1);
    check("f_if_rdata",  if_rdata, 32'h00A0_0093);
    check("f_mem_req_off", mem_req, 0);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();
    check("f_if_ready_once", if_ready, 0);
    check("f_no_second_req", mem_req,  0);
    check("f_if_rdata_hold", if_rdata, 32'h00A0_0093);

    // ---------------- simultaneous D write + I fetch ----------------
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0040;
    d_wdata = 32'h0000_55AA;
    d_size  = 2'b01;
    if_req  = 1'b1;
    if_addr = 32'h0000_0200;
    tick();                                  // D wins
    check("s_mem_req",   mem_req,   1);
    check("s_mem_we",    mem_we,    1);
    check("s_mem_addr",  mem_addr,  32'h40);
    check("s_mem_wdata", mem_wdata, 32'h55AA);
    check("s_mem_size",  mem_size,  2'b01);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("s_d_ready",        d_ready,  1);
    check("s_if_ready_quiet", if_ready, 0);
    check("s_d_rdata_write",  d_rdata,  0);
    d_req   = 1'b0;
    d_we    = 1'b0;
    mem_ack = 1'b0;
    tick();                                  // turnaround cycle
    check("s_turnaround", mem_req, 0);
    tick();                                  // I granted
    check("s_i_mem_req",  mem_req,  1);
    check("s_i_mem_addr", mem_addr, 32'h200);
    check("s_i_mem_we",   mem_we,   0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    check("s_if_ready", if_ready, 1);
    check("s_if_rdata", if_rdata, 32'h1234_5678);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();

    // ---------------- starvation: 4 D grants, then I ----------------
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0080;
    d_size  = 2'b10;
    if_req  = 1'b1;
    if_addr = 32'h0000_0300;
    for (int g = 1; g <= 5; g++) begin
      tick();                                // grant edge
      check($sformatf("st_addr_g%0d", g), mem_addr, (g <= 4) ? 32'h80 : 32'h300);
      mem_ack   = 1'b1;
      mem_rdata = 32'(g);
      tick();                                // completion
      mem_ack = 1'b0;
      if (g <= 4) begin
        check($sformatf("st_d_ready_g%0d", g), d_ready,  1);
        check($sformatf("st_d_rdata_g%0d", g), d_rdata,  32'(g));
        check($sformatf("st_streak_g%0d", g),  32'(dut.d_streak), 32'(g));
        tick();                              // turnaround cycle
      end else begin
        check("st_if_ready", if_ready, 1);
        check("st_if_rdata", if_rdata, 32'd5);
        check("st_streak_cleared", 32'(dut.d_streak), 0);
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
      end
    end

    // ---------------- timeout on a D read ----------------
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0500;
    tick();                                  // busy cycle 1
    check("t_mem_req_start", mem_req, 1);
    ticks(15);                               // busy cycle 16
    check("t_mem_req_last", mem_req,  1);
    check("t_no_ready_yet", d_ready,  0);
    tick();                                  // abort
    check("t_mem_req_drop", mem_req,   0);
    check("t_d_ready",      d_ready,   1);
    check("t_resp_err",     resp_err,  1);
    check("t_d_rdata_zero", d_rdata,   0);
    check("t_bus_error",    bus_error, 1);
    d_req = 1'b0;
    tick();
    check("t_resp_err_pulse", resp_err,  0);
    check("t_bus_err_sticky", bus_error, 1);
    tick();

    // ---------------- ack on the last allowed cycle is not a timeout ----------------
    d_req  = 1'b1;
    d_addr = 32'h0000_0504;
    tick();                                  // busy cycle 1
    ticks(15);                               // busy cycle 16
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    check("l_d_ready",  d_ready,  1);
    check("l_resp_err", resp_err, 0);
    check("l_d_rdata",  d_rdata,  32'h0BAD_F00D);
    d_req   = 1'b0;
    mem_ack = 1'b0;
    tick();

    // ---------------- stray ack in IDLE ----------------
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0BAD;
    ticks(2);
    check("x_if_ready", if_ready, 0);
    check("x_d_ready",  d_ready,  0);
    check("x_mem_req",  mem_req,  0);
    check("x_if_rdata", if_rdata, 32'd5);
    check("x_d_rdata",  d_rdata,  32'h0BAD_F00D);
    mem_ack = 1'b0;
    tick();

    // ---------------- reset mid-transaction ----------------
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0600;
    d_wdata = 32'h0000_0077;
    d_size  = 2'b10;
    tick();
    check("r_busy", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("r_mem_req",   mem_req,   0);
    check("r_mem_we",    mem_we,    0);
    check("r_mem_addr",  mem_addr,  0);
    check("r_mem_wdata", mem_wdata, 0);
    check("r_mem_size",  mem_size,  0);
    check("r_bus_error", bus_error, 0);
    check("r_d_rdata",   d_rdata,   0);
    check("r_if_rdata",  if_rdata,  0);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    check("r_no_d_ready", d_ready, 0);
    reset = 1'b1;
    tick();
    check("r_idle_after", mem_req, 0);
    d_req  = 1'b1;
    d_addr = 32'h0000_0700;
    tick();
    check("r_fresh_req",  mem_req,  1);
    check("r_fresh_addr", mem_addr, 32'h700);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_CAFE;
    tick();
    check("r_fresh_ready", d_ready,  1);
    check("r_fresh_rdata", d_rdata,  32'hCAFE);
    check("r_fresh_err",   resp_err, 0);
    d_req   = 1'b0;
    mem_ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while a fetch request waits.
REQ-002 SHALL have parameter TIMEOUT, default 16: cycles in a BUSY state without mem_ack before the transaction is aborted.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; the block is held in reset while reset=0.
REQ-005 SHALL have ports if_req (in, 1), if_addr (in, 32), if_ready (out, 1) and if_rdata (out, 32): the instruction-fetch requester; fetches are always reads, size word.
REQ-006 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, 32), d_wdata (in, 32), d_size (in, 2), d_ready (out, 1) and d_rdata (out, 32): the load/store requester.
REQ-007 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_size (out, 2), mem_ack (in, 1) and mem_rdata (in, 32): the shared single-port memory.
REQ-008 SHALL have ports resp_err (out, 1), a one-cycle pulse accompanying an aborted response, and bus_error (out, 1), a sticky flag.

Function
REQ-009 SHALL use three states: IDLE, BUSY_I and BUSY_D.
REQ-010 In IDLE, SHALL sample both requests and latch the winner's addr/we/wdata/size into internal registers; the next state is BUSY_I or BUSY_D.
REQ-011 Arbitration SHALL give the data port fixed priority, except that the fetch port wins when if_req=1 and d_streak==STARVE_LIMIT.
REQ-012 d_streak SHALL be a counter that increments on each D grant made while if_req=1, clears on any I grant, and clears on a D grant made with if_req=0; it saturates at STARVE_LIMIT.
REQ-013 mem_req SHALL be 1 in BUSY_I/BUSY_D only, and mem_addr/mem_we/mem_wdata/mem_size SHALL come from the latched registers (stable for the whole transaction); mem_we=0 in BUSY_I.
REQ-014 When mem_ack=1 in a BUSY state, SHALL register mem_rdata into the owner's rdata, pulse the owner's ready for exactly the next cycle and return to IDLE.
REQ-015 Minimum latency SHALL be: req sampled in cycle 0, mem_req in cycle 1, ack in cycle 1, ready in cycle 2.
REQ-016 In IDLE, a requester whose ready is 1 that cycle SHALL be ignored for arbitration; this prevents re-granting a completed request.
REQ-017 rdata SHALL hold its value until the next completion for that port; for writes, d_rdata is unchanged.
REQ-018 A cycle counter SHALL run in BUSY states and clear on entry; when it reaches TIMEOUT with no ack, SHALL drop mem_req, pulse the owner's ready with resp_err=1 and rdata=0, set bus_error, and return to IDLE.
REQ-019 mem_ack in IDLE SHALL be ignored.
REQ-020 Requests arriving while BUSY SHALL wait; the requester holds req and its fields stable until ready.
REQ-021 If both requests arrive together with d_streak<STARVE_LIMIT, SHALL grant D, then grant I on the next IDLE if if_req is still 1 and d_req=0 or the limit is reached.

Reset
REQ-022 While reset=0, SHALL force state=IDLE, d_streak=0, the timeout counter to 0, and mem_req, mem_we, if_ready, d_ready, resp_err and bus_error to 0, with if_rdata, d_rdata, mem_addr, mem_wdata and mem_size all 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction with no ready pulse; after release, operation SHALL start from IDLE.

Verification
REQ-024 SHALL cover a single fetch: if_addr=0x100 and mem_rdata=0x00A00093 with ack one cycle after mem_req, giving if_ready pulsed once, if_rdata=0x00A00093 and no second mem_req.
REQ-025 SHALL cover simultaneous requests: d_req (write 0x55AA to 0x40, size=01) and if_req together, giving the D transaction first with mem_we=1, then the I transaction.
REQ-026 SHALL cover starvation: d_req held continuously and if_req=1 with STARVE_LIMIT=4, so that the 5th grant goes to I and d_streak returns to 0.
REQ-027 SHALL cover timeout: no mem_ack for 16 BUSY cycles, giving mem_req dropped, d_ready=1 with resp_err=1 and d_rdata=0, and bus_error staying 1 until reset.
REQ-028 SHALL cover reset mid-transaction: reset=0 during BUSY_D, giving all outputs 0 immediately with no d_ready pulse, and a fresh request after release that completes normally.
REQ-029 SHALL cover a stray ack: mem_ack=1 in IDLE, giving no ready pulse and no state change.
